// File: rtl/vx_gbar_ctrl.sv
// Global barrier controller: round-robin accepts one arrival per cycle from the cores,
// tracks per-barrier counts/masks and broadcasts a one-cycle release when a barrier fills.
module vx_gbar_ctrl #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_core_id,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic                          rsp_valid,
  output logic [NB_WIDTH-1:0]           rsp_id,
  output logic                          err_dup,
  output logic                          err_size,
  output logic                          busy
);

  logic [NC_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_BARRIERS-1:0][NC_WIDTH:0]    count_q, count_d;
  logic [NUM_BARRIERS-1:0][NC_WIDTH-1:0]  size_q, size_d;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [NB_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic                err_dup_q, err_dup_d;
  logic                err_size_q, err_size_d;
  logic                busy_q, busy_d;

  logic                gnt_found;
  logic [NC_WIDTH-1:0] gnt_idx;
  logic                accept;
  logic [NB_WIDTH-1:0] acc_id;
  logic [NC_WIDTH-1:0] acc_size;
  logic [NC_WIDTH-1:0] acc_core;
  logic [NUM_CORES-1:0] core_oh;
  logic                b_open;
  logic [NC_WIDTH-1:0] eff_size;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(ptr_q) + k) % NUM_CORES;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = NC_WIDTH'(idx);
      end
    end
  end

  assign accept = gnt_found & ~reset;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign req_ready[gi] = accept && (gnt_idx == NC_WIDTH'(gi));
      assign core_oh[gi]   = (acc_core == NC_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    acc_id   = '0;
    acc_size = '0;
    acc_core = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt_idx == NC_WIDTH'(i)) begin
        acc_id   = req_id[i*NB_WIDTH +: NB_WIDTH];
        acc_size = req_size_m1[i*NC_WIDTH +: NC_WIDTH];
        acc_core = req_core_id[i*NC_WIDTH +: NC_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    size_d      = size_q;
    mask_d      = mask_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    err_dup_d   = err_dup_q;
    err_size_d  = err_size_q;
    b_open      = (count_q[acc_id] != '0);
    // A closed barrier takes its size from the arriving request.
    eff_size    = b_open ? size_q[acc_id] : acc_size;

    if (accept) begin
      ptr_d = (gnt_idx == NC_WIDTH'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
      if (!b_open)
        size_d[acc_id] = acc_size;
      if (b_open && (acc_size != size_q[acc_id]))
        err_size_d = 1'b1;
      if (|(mask_q[acc_id] & core_oh)) begin
        err_dup_d = 1'b1;
      end else if ({1'b0, eff_size} == count_q[acc_id]) begin
        count_d[acc_id] = '0;
        mask_d[acc_id]  = '0;
        rsp_valid_d     = 1'b1;
        rsp_id_d        = acc_id;
      end else begin
        count_d[acc_id] = count_q[acc_id] + 1'b1;
        mask_d[acc_id]  = mask_q[acc_id] | core_oh;
      end
    end

    busy_d = 1'b0;
    for (int i = 0; i < NUM_BARRIERS; i++)
      busy_d = busy_d | (count_d[i] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      count_q     <= '0;
      size_q      <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      err_dup_q   <= 1'b0;
      err_size_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      size_q      <= size_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      err_dup_q   <= err_dup_d;
      err_size_q  <= err_size_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign err_dup   = err_dup_q;
  assign err_size  = err_size_q;
  assign busy      = busy_q;

endmodule

// File: doc/vx_gbar_ctrl.md
Name: VX_gbar_ctrl

Overview:
Global barrier controller shared by all cores of a cluster. It accepts one barrier-arrival request per cycle from NUM_CORES requesters under round-robin arbitration. It tracks per-barrier arrival counts and arrival masks. When the last participant arrives, it broadcasts a one-cycle release response carrying the barrier id. It sits between the per-core gbar request/response ports and the cluster, as the resource owner for global barriers.

Parameters:
NUM_CORES, 4, number of requesting cores (>=1)
NUM_BARRIERS, 8, number of barrier ids tracked (power of two)
NC_WIDTH, `UP(`CLOG2(NUM_CORES)), core id / size field width
NB_WIDTH, `UP(`CLOG2(NUM_BARRIERS)), barrier id width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_valid  input  NUM_CORES  per-core arrival request valid
req_id  input  NUM_CORES*NB_WIDTH  per-core barrier id
req_size_m1  input  NUM_CORES*NC_WIDTH  per-core participant count minus one
req_core_id  input  NUM_CORES*NC_WIDTH  per-core requester core id
req_ready  output  NUM_CORES  per-core grant/accept
rsp_valid  output  1  release broadcast pulse
rsp_id  output  NB_WIDTH  released barrier id
err_dup  output  1  sticky: core arrived twice at the same open barrier
err_size  output  1  sticky: size_m1 disagrees with the latched size
busy  output  1  any barrier has outstanding arrivals

Behaviour:
- Single clock domain. Reset is asynchronous, active-high: all state and outputs clear immediately and stay clear while reset is high.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, err_dup=0, err_size=0, busy=0, all counters/masks/size registers=0, rr pointer=0.
- Arbitration: combinational round-robin over req_valid, starting at the pointer. At most one req_ready bit is high per cycle. req_ready[i] depends only on req_valid and the pointer, never on req_ready.
- Accept = req_valid[g] & req_ready[g]. On accept, the pointer becomes (g+1) mod NUM_CORES. With no accept, the pointer holds.
- Requesters hold valid and payload stable until accepted. The block never drops a held request.
- Per-barrier state:
  - count[NC_WIDTH+1]
  - size_m1[NC_WIDTH]
  - mask[NUM_CORES]
  - open bit (open = count != 0)
- On accept for barrier b with core c:
  - If !open[b]: latch size_m1[b] from the request.
  - If open[b] and the request size differs from size_m1[b]: set err_size. The latched value is kept and the arrival still counts.
  - If mask[b][c] is already set: set err_dup. The request is consumed, but count and mask are unchanged.
  - Otherwise: mask[b][c] <= 1 and count[b] <= count[b]+1.
- Completion: a counted arrival where the effective size (latched, or the incoming one if !open) equals count[b] (the pre-increment value).
  - At the same edge: count[b], mask[b] and the open state clear.
  - Next cycle: rsp_valid=1 for exactly one cycle, with rsp_id=b.
- Latency: accept in cycle N -> rsp_valid in cycle N+1. size_m1=0 releases in N+1.
- rsp has no ready; it is a broadcast and is consumed unconditionally.
- Arrivals for b in the cycle rsp_valid(b) is high start a new generation (the counter is already cleared).
- Back-to-back completions on different ids give consecutive rsp pulses. Only one accept per cycle, so at most one completion per cycle and no response conflict.
- Error flags are sticky until reset.
- busy = OR of all open bits, registered (reflects post-edge state).
- Reset mid-operation: all partial barriers are discarded and no rsp is issued for them. Requests held across reset are re-arbitrated from pointer 0 after release.

Test Plan:
1. Assert reset with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0. After deassert, core 0 is granted first.
2. Cores 0-3 all valid: id=3, size_m1=3 in cycle 0 -> grants in cycles 0,1,2,3 (cores 0..3); busy=1 in cycles 1-3; rsp_valid=1, rsp_id=3 in cycle 4 only; busy=0 in cycle 4.
3. Core 2 alone: id=5, size_m1=0 -> accepted in cycle 0; rsp_valid, rsp_id=5 in cycle 1; err flags stay 0.
4. Interleave id=1 (size_m1=1) from cores 0,1 and id=2 (size_m1=1) from cores 2,3, all valid at once -> order is 0,1,2,3; rsp id=1 at cycle 2, rsp id=2 at cycle 4.
5. Core 1 arrives twice at id=4 (size_m1=1) -> second request accepted, err_dup=1, no rsp. Core 3 then arrives -> rsp id=4. err_dup remains 1.
6. Core 0 arrives at id=6 with size_m1=2, then core 1 with size_m1=1 -> err_size=1, no release. Pulse reset -> flags=0, busy=0, and no rsp for id 6 ever appears.
